gcn_aggregation_engine: RTL and testbench

- Downstream neighbour of the transformation stage in the GCN pipeline.
- After the feature×weight (FM_WM) product scratch is fully written (transformation `done`), this block walks the COO adjacency edge list and accumulates product rows into per-node aggregate rows (A·(F·W)).
- It then computes the per-node argmax class and presents it on `y`, with a done flag.

---
 rtl/gcn_agg_pkg.sv | 7 +
 rtl/gcn_row_argmax.sv | 22 ++
 rtl/gcn_aggregation_engine.sv | 110 +++++++++++
 tb/tb_gcn_aggregation_engine.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/gcn_agg_pkg.sv
// gcn_agg_pkg: shared FSM state encoding and timing constants for the GCN aggregation engine
package gcn_agg_pkg;
  typedef enum logic [3:0] {
    IDLE, CLEAR, EDGE_RD, EDGE_CAP, ROWB_RD, ROWB_ACC, ROWA_RD, ROWA_ACC, ARGMAX, DONE
  } agg_state_t;
  localparam int CYCLES_PER_EDGE = 6;
endpackage

// File: rtl/gcn_row_argmax.sv
// gcn_row_argmax: combinational unsigned argmax over one row, ties resolve to the lowest column
module gcn_row_argmax
  import gcn_agg_pkg::*;
#(
  parameter int WEIGHT_COLS = 3,
  parameter int AGG_WIDTH = 19,
  parameter int CLASS_W = $clog2(WEIGHT_COLS)
) (
  input  logic [WEIGHT_COLS*AGG_WIDTH-1:0] row,
  output logic [CLASS_W-1:0]               cls
);
  logic [AGG_WIDTH-1:0] best;
  always_comb begin
    best = row[AGG_WIDTH-1:0];
    cls = '0;
    for (int c = 1; c < WEIGHT_COLS; c++)
      if (row[c*AGG_WIDTH +: AGG_WIDTH] > best) begin
        best = row[c*AGG_WIDTH +: AGG_WIDTH];
        cls = CLASS_W'(c);
      end
  end
endmodule

// File: rtl/gcn_aggregation_engine.sv
// gcn_aggregation_engine: walks the COO edge list accumulating FM_WM rows per node, then emits per-node argmax
module gcn_aggregation_engine
  import gcn_agg_pkg::*;
#(
  parameter int FEATURE_ROWS = 6,
  parameter int WEIGHT_COLS = 3,
  parameter int NUM_EDGES = 6,
  parameter int DOT_WIDTH = 16,
  parameter int AGG_WIDTH = DOT_WIDTH + 3,
  parameter int NODE_W = $clog2(FEATURE_ROWS),
  parameter int EDGE_W = $clog2(NUM_EDGES),
  parameter int CLASS_W = $clog2(WEIGHT_COLS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  output logic                             coo_read_en,
  output logic [EDGE_W-1:0]                coo_address,
  input  logic [2*NODE_W-1:0]              coo_data_in,
  output logic                             fm_wm_read_en,
  output logic [NODE_W-1:0]                fm_wm_row_address,
  input  logic [WEIGHT_COLS*DOT_WIDTH-1:0] fm_wm_row_data,
  output logic [FEATURE_ROWS*CLASS_W-1:0]  y,
  output logic                             busy,
  output logic                             done
);
  agg_state_t state, state_n;
  logic [AGG_WIDTH-1:0] acc [FEATURE_ROWS][WEIGHT_COLS];
  logic [AGG_WIDTH-1:0] row_ext [WEIGHT_COLS];
  logic [WEIGHT_COLS*AGG_WIDTH-1:0] arg_row;
  logic [EDGE_W-1:0] edge_cnt;
  logic [NODE_W-1:0] node_cnt, node_a, node_b;
  logic [CLASS_W-1:0] cls;
  logic in_rng, last_edge, last_node;

  for (genvar c = 0; c < WEIGHT_COLS; c++) begin : g_col
    assign row_ext[c] = AGG_WIDTH'(fm_wm_row_data[c*DOT_WIDTH +: DOT_WIDTH]);
    assign arg_row[c*AGG_WIDTH +: AGG_WIDTH] = acc[node_cnt][c];
  end

  gcn_row_argmax #(.WEIGHT_COLS(WEIGHT_COLS), .AGG_WIDTH(AGG_WIDTH), .CLASS_W(CLASS_W)) u_argmax (
    .row(arg_row),
    .cls(cls)
  );

  // an edge touching a nonexistent node contributes nothing to either end
  assign in_rng = ({1'b0, node_a} < (NODE_W+1)'(FEATURE_ROWS)) && ({1'b0, node_b} < (NODE_W+1)'(FEATURE_ROWS));
  assign last_edge = edge_cnt == EDGE_W'(NUM_EDGES - 1);
  assign last_node = node_cnt == NODE_W'(FEATURE_ROWS - 1);

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;

  always_comb begin
    state_n = state;
    coo_read_en = 1'b0;
    fm_wm_read_en = 1'b0;
    coo_address = edge_cnt;
    fm_wm_row_address = node_a;
    case (state)
      IDLE:     state_n = start ? CLEAR : IDLE;
      CLEAR:    state_n = EDGE_RD;
      EDGE_RD:  begin coo_read_en = 1'b1; state_n = EDGE_CAP; end
      EDGE_CAP: state_n = ROWB_RD;
      ROWB_RD:  begin fm_wm_read_en = 1'b1; fm_wm_row_address = node_b; state_n = ROWB_ACC; end
      ROWB_ACC: state_n = ROWA_RD;
      ROWA_RD:  begin fm_wm_read_en = 1'b1; state_n = ROWA_ACC; end
      ROWA_ACC: state_n = last_edge ? ARGMAX : EDGE_RD;
      ARGMAX:   state_n = last_node ? DONE : ARGMAX;
      DONE:     state_n = start ? CLEAR : DONE;
      default:  state_n = IDLE;
    endcase
    busy = state != IDLE && state != DONE;
    done = state == DONE;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int n = 0; n < FEATURE_ROWS; n++)
        for (int c = 0; c < WEIGHT_COLS; c++) acc[n][c] <= '0;
      edge_cnt <= '0;
      node_cnt <= '0;
      node_a <= '0;
      node_b <= '0;
      y <= '0;
    end else
      case (state)
        CLEAR: begin
          for (int n = 0; n < FEATURE_ROWS; n++)
            for (int c = 0; c < WEIGHT_COLS; c++) acc[n][c] <= '0;
          edge_cnt <= '0;
          node_cnt <= '0;
        end
        EDGE_CAP: {node_a, node_b} <= coo_data_in;
        ROWB_ACC:
          if (in_rng)
            for (int c = 0; c < WEIGHT_COLS; c++) acc[node_a][c] <= acc[node_a][c] + row_ext[c];
        ROWA_ACC: begin
          if (in_rng && node_a != node_b)
            for (int c = 0; c < WEIGHT_COLS; c++) acc[node_b][c] <= acc[node_b][c] + row_ext[c];
          if (!last_edge) edge_cnt <= edge_cnt + 1'b1;
        end
        ARGMAX: begin
          y[node_cnt*CLASS_W +: CLASS_W] <= cls;
          if (!last_node) node_cnt <= node_cnt + 1'b1;
        end
        default: ;
      endcase
endmodule

// File: tb/tb_gcn_aggregation_engine.sv
// tb_gcn_aggregation_engine: directed checks of aggregation, argmax, timing, reset and wrap behaviour
module tb_gcn_aggregation_engine;
  import gcn_agg_pkg::*;
  logic clk = 0, reset = 1, start = 0;
  logic coo_read_en, fm_wm_read_en, coo_read_en17, fm_wm_read_en17;
  logic [2:0] coo_address, fm_wm_row_address, coo_address17, fm_wm_row_address17;
  logic [5:0] coo_data_in, coo_data_in17;
  logic [47:0] fm_wm_row_data, fm_wm_row_data17;
  logic [11:0] y, y17;
  logic busy, done, busy17, done17;
  logic [5:0] coo_mem [8];
  logic [47:0] fm_mem [8];
  int total = 0, bad = 0;
  int done_c, coo_n, fm_n, d0, b0;
  logic [11:0] y_mid;
  localparam int DONE_AT = 1 + CYCLES_PER_EDGE * 6 + 6;

  always #5 clk = ~clk;

  gcn_aggregation_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .coo_read_en(coo_read_en), .coo_address(coo_address), .coo_data_in(coo_data_in),
    .fm_wm_read_en(fm_wm_read_en), .fm_wm_row_address(fm_wm_row_address), .fm_wm_row_data(fm_wm_row_data),
    .y(y), .busy(busy), .done(done)
  );

  gcn_aggregation_engine #(.AGG_WIDTH(17)) dut17 (
    .clk(clk), .reset(reset), .start(start),
    .coo_read_en(coo_read_en17), .coo_address(coo_address17), .coo_data_in(coo_data_in17),
    .fm_wm_read_en(fm_wm_read_en17), .fm_wm_row_address(fm_wm_row_address17), .fm_wm_row_data(fm_wm_row_data17),
    .y(y17), .busy(busy17), .done(done17)
  );

  always @(posedge clk) begin
    if (coo_read_en) coo_data_in <= coo_mem[coo_address];
    if (fm_wm_read_en) fm_wm_row_data <= fm_mem[fm_wm_row_address];
    if (coo_read_en17) coo_data_in17 <= coo_mem[coo_address17];
    if (fm_wm_read_en17) fm_wm_row_data17 <= fm_mem[fm_wm_row_address17];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] row(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    return {c, b, a};
  endfunction

  task automatic load(input logic [5:0] e0, input logic [5:0] rest);
    coo_mem[0] = e0;
    for (int i = 1; i < 8; i++) coo_mem[i] = rest;
    for (int i = 0; i < 8; i++) fm_mem[i] = '0;
  endtask

  // start one run, optionally pulse start again at cycle pulse_at, and record timing/strobes
  task automatic go(input int pulse_at);
    int c;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    c = 0;
    coo_n = 0; fm_n = 0; done_c = -1;
    d0 = done; b0 = busy;
    while (!done && c < 100) begin
      coo_n += coo_read_en;
      fm_n += fm_wm_read_en;
      if (c == 20) y_mid = y;
      if (c == pulse_at) start = 1;
      @(posedge clk);
      #1 start = 0;
      c++;
    end
    if (done) done_c = c;
  endtask

  initial begin
    load({3'd5, 3'd5}, {3'd5, 3'd5});
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_y", y, 0);
    chk("rst_strobes", {coo_read_en, fm_wm_read_en}, 0);
    @(negedge clk) reset = 0;

    load({3'd0, 3'd1}, {3'd5, 3'd5});
    fm_mem[0] = row(1, 2, 3);
    fm_mem[1] = row(5, 1, 0);
    go(-1);
    chk("t1_done_at", done_c, DONE_AT);
    chk("t1_y", y, 12'h008);
    chk("t1_acc0_0", dut.acc[0][0], 5);
    chk("t1_acc1_2", dut.acc[1][2], 3);
    chk("t1_coo_strobes", coo_n, 6);
    chk("t1_fm_strobes", fm_n, 12);

    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (22) @(posedge clk);
    #1;
    chk("mid_state", dut.state, ROWB_ACC);
    chk("mid_edge", dut.edge_cnt, 3);
    @(negedge clk) reset = 1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_y", y, 0);
    @(posedge clk);
    #1;
    chk("mid_rst_idle", dut.state, IDLE);
    @(negedge clk) reset = 0;
    go(-1);
    chk("rerun_done_at", done_c, DONE_AT);
    chk("rerun_y", y, 12'h008);

    load({3'd2, 3'd2}, {3'd5, 3'd5});
    fm_mem[2] = row(4, 9, 9);
    go(10);
    chk("t2_busy_start_done_at", done_c, DONE_AT);
    chk("t2_y", y, 12'h010);
    chk("t2_acc2_0", dut.acc[2][0], 4);
    chk("t2_acc2_1", dut.acc[2][1], 9);
    go(-1);
    chk("restart_done_low", d0, 0);
    chk("restart_busy", b0, 1);
    chk("restart_done_at", done_c, DONE_AT);
    chk("restart_y", y, 12'h010);

    load({3'd3, 3'd7}, {3'd5, 3'd5});
    fm_mem[3] = row(7, 7, 7);
    fm_mem[7] = row(1, 1, 1);
    go(-1);
    chk("t3_y_held", y_mid, 12'h010);
    chk("t3_y", y, 0);
    chk("t3_acc3_0", dut.acc[3][0], 0);
    chk("t3_coo_strobes", coo_n, 6);
    chk("t3_fm_strobes", fm_n, 12);
    chk("t3_done_at", done_c, DONE_AT);

    load({3'd4, 3'd0}, {3'd4, 3'd0});
    fm_mem[0] = row(16'hFFFF, 16'hAAAA, 0);
    go(-1);
    chk("t4_acc4_0", dut.acc[4][0], 32'h5FFFA);
    chk("t4_acc4_1", dut.acc[4][1], 32'h3FFFC);
    chk("t4_y", y, 0);
    chk("t4w_done", done17, 1);
    chk("t4w_acc4_0", dut17.acc[4][0], 32'h1FFFA);
    chk("t4w_y", y17, 12'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
